// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock sequencer.
// The timer width is derived from the longest interval it must count.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_LOSS_W        = 8;

    function automatic int timer_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop bit synchronizer, asynchronously cleared to 0.
// Used for PLL lock and for outclk-domain reset release.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, waits for a stable lock, then releases system reset.
// Retries on lock timeout and latches a failure after repeated timeouts.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int LOSS_W        = DEF_LOSS_W
) (
    input  logic              refclk,
    input  logic              reset_n,
    input  logic              locked,
    input  logic              soft_reset,
    output logic              pll_rst,
    output logic              sys_reset_n,
    output logic              ready,
    output logic              fail,
    output logic [1:0]        retry_count,
    output logic [LOSS_W-1:0] loss_count
);

    localparam int TW = timer_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [TW-1:0] RST_END = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_END  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] ST_END  = TW'(STABLE_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0] LOSS_SAT = '1;

    logic              lk;
    state_t            state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [1:0]        retry_nxt;
    logic [LOSS_W-1:0] loss_nxt;

    sync_2ff u_lk_sync (
        .clk   (refclk),
        .rst_n (reset_n),
        .d     (locked),
        .q     (lk)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        retry_nxt = retry_count;
        loss_nxt  = loss_count;
        if (soft_reset) begin
            state_nxt = PLL_RESET;
            timer_nxt = '0;
            retry_nxt = '0;
        end else begin
            unique case (state)
                PLL_RESET: begin
                    if (timer == RST_END) begin
                        state_nxt = WAIT_LOCK;
                        timer_nxt = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_nxt = STABLE;
                        timer_nxt = '0;
                    end else if (timer == TO_END) begin
                        timer_nxt = '0;
                        retry_nxt = retry_count + 2'd1;
                        state_nxt = (retry_nxt == RETRY_MAX) ? FAIL : PLL_RESET;
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state_nxt = WAIT_LOCK;
                        timer_nxt = '0;
                    end else if (timer == ST_END) begin
                        state_nxt = RUN;
                        timer_nxt = '0;
                        retry_nxt = '0;
                    end
                end
                RUN: begin
                    timer_nxt = '0;
                    if (!lk) begin
                        state_nxt = PLL_RESET;
                        if (loss_count != LOSS_SAT)
                            loss_nxt = loss_count + 1'b1;
                    end
                end
                FAIL: timer_nxt = '0;
                default: begin
                    state_nxt = PLL_RESET;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change cleanly on the same edge.
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PLL_RESET;
            timer       <= '0;
            retry_count <= '0;
            loss_count  <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            retry_count <= retry_nxt;
            loss_count  <= loss_nxt;
            pll_rst     <= (state_nxt == PLL_RESET) || (state_nxt == FAIL);
            sys_reset_n <= (state_nxt == RUN);
            ready       <= (state_nxt == RUN);
            fail        <= (state_nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: stimulus queues expected output-change events,
// a monitor pops one per observed change and checks cycle and value.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       reset_n = 1'b1;
    logic       locked = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pll_rst, sys_reset_n, ready, fail;
    logic [1:0] retry_count;
    logic [7:0] loss_count;

    typedef struct {
        int          cyc;
        logic [13:0] v;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [13:0] prev = '1;

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (100),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .LOSS_W        (8)
    ) dut (
        .refclk      (refclk),
        .reset_n     (reset_n),
        .locked      (locked),
        .soft_reset  (soft_reset),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    function automatic logic [13:0] mk(input logic p, input logic s,
                                       input logic r, input logic f,
                                       input int rt, input int ls);
        logic [1:0] rt2;
        logic [7:0] ls8;
        rt2 = rt[1:0];
        ls8 = ls[7:0];
        return {p, s, r, f, rt2, ls8};
    endfunction

    task automatic expect_ev(input int c, input logic [13:0] v);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge refclk);
            #2;
        end
    endtask

    always @(negedge refclk) begin
        logic [13:0] now;
        ev_t e;
        now = {pll_rst, sys_reset_n, ready, fail, retry_count, loss_count};
        if (now !== prev) begin
            prev = now;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change: got cyc=%0d v=%h, want no change",
                         cyc, now);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.v !== now) begin
                    failures++;
                    $display("FAIL event: got cyc=%0d v=%h, want cyc=%0d v=%h",
                             cyc, now, e.cyc, e.v);
                end
            end
        end
    end

    initial begin
        int n, w, s, m, ls;

        // Power-on reset, then 4-cycle PLL reset pulse.
        expect_ev(1, mk(1, 0, 0, 0, 0, 0));
        #1 reset_n = 1'b0;
        wait_to(2);
        reset_n = 1'b1;
        expect_ev(6, mk(0, 0, 0, 0, 0, 0));

        // Lock 10 cycles into WAIT_LOCK.
        wait_to(16);
        locked = 1'b1;
        expect_ev(27, mk(0, 1, 1, 0, 0, 0));

        // soft_reset coincides with the lock loss reaching the FSM.
        wait_to(32);
        n = cyc;
        locked = 1'b0;
        expect_ev(n + 3, mk(1, 0, 0, 0, 0, 0));
        expect_ev(n + 7, mk(0, 0, 0, 0, 0, 0));
        wait_to(n + 2);
        soft_reset = 1'b1;
        wait_to(n + 3);
        soft_reset = 1'b0;
        wait_to(n + 7);
        locked = 1'b1;
        expect_ev(n + 18, mk(0, 1, 1, 0, 0, 0));
        wait_to(n + 20);

        // Repeated lock losses in RUN; counter saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            ls = (i > 255) ? 255 : i;
            n = cyc;
            locked = 1'b0;
            expect_ev(n + 3, mk(1, 0, 0, 0, 0, ls));
            expect_ev(n + 7, mk(0, 0, 0, 0, 0, ls));
            wait_to(n + 7);
            locked = 1'b1;
            expect_ev(n + 18, mk(0, 1, 1, 0, 0, ls));
            wait_to(n + 20);
        end

        // Lock never returns: three timeouts then FAIL.
        n = cyc;
        locked = 1'b0;
        w = n + 7;
        expect_ev(n + 3, mk(1, 0, 0, 0, 0, 255));
        expect_ev(w, mk(0, 0, 0, 0, 0, 255));
        expect_ev(w + 100, mk(1, 0, 0, 0, 1, 255));
        expect_ev(w + 104, mk(0, 0, 0, 0, 1, 255));
        expect_ev(w + 204, mk(1, 0, 0, 0, 2, 255));
        expect_ev(w + 208, mk(0, 0, 0, 0, 2, 255));
        expect_ev(w + 308, mk(1, 0, 0, 1, 3, 255));
        wait_to(w + 330);

        // soft_reset leaves FAIL.
        s = cyc;
        soft_reset = 1'b1;
        expect_ev(s + 1, mk(1, 0, 0, 0, 0, 255));
        expect_ev(s + 5, mk(0, 0, 0, 0, 0, 255));
        wait_to(s + 1);
        soft_reset = 1'b0;

        // Two-cycle lock dropout at stable count 5 restarts the interval.
        wait_to(s + 8);
        m = cyc;
        locked = 1'b1;
        wait_to(m + 5);
        locked = 1'b0;
        wait_to(m + 7);
        locked = 1'b1;
        expect_ev(m + 18, mk(0, 1, 1, 0, 0, 255));
        wait_to(m + 23);

        // Async reset in the middle of STABLE.
        n = cyc;
        locked = 1'b0;
        expect_ev(n + 3, mk(1, 0, 0, 0, 0, 255));
        expect_ev(n + 7, mk(0, 0, 0, 0, 0, 255));
        wait_to(n + 7);
        locked = 1'b1;
        wait_to(n + 13);
        expect_ev(n + 13, mk(1, 0, 0, 0, 0, 0));
        reset_n = 1'b0;
        locked = 1'b0;
        #1;
        checks++;
        if ({pll_rst, sys_reset_n, ready, fail, retry_count, loss_count}
            !== mk(1, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL async_reset: got %h, want %h",
                     {pll_rst, sys_reset_n, ready, fail, retry_count, loss_count},
                     mk(1, 0, 0, 0, 0, 0));
        end
        wait_to(n + 16);
        reset_n = 1'b1;
        expect_ev(n + 20, mk(0, 0, 0, 0, 0, 0));
        wait_to(n + 30);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got %0d left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
